ram_clear_seq: RTL and testbench
================================

# ram_clear_seq

Write-request sequencer that sweeps a contiguous memory range and issues one single-word write per address to a downstream SDRAM/DDR3 controller through a req/ack handshake. It sits directly upstream of the `sdram` and `ddram` controller instances. It replaces the free-running clear counter with a bounded, restartable, pausable sweep that reports progress and completion. Fill data is zero, or optionally a pseudo-random pattern for memory test.

## Interface
Parameters:
- `ADDR_W`, 25: width of `mem_addr`.
- `DATA_W`, 16: width of `mem_din` (≥16).
- `START_ADDR`, 0: first address written.
- `END_ADDR`, 2**ADDR_W-1: last address written, inclusive; must be ≥ `START_ADDR`.
- `SETTLE_CYC`, 9: idle cycles between `start` and the first request.

Ports:
- `clk_sys` in 1: single clock for all logic.
- `RESET` in 1: reset, synchronous and active-high.
- `start` in 1: begin a sweep; sampled only in IDLE or DONE.
- `pause` in 1: hold off new requests, e.g. driven from `~locked`.
- `mem_req` out 1: write request.
- `mem_ack` in 1: controller accepts the current request.
- `mem_addr` out ADDR_W: write address.
- `mem_din` out DATA_W: write data.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete; held until the next `start` or `RESET`.
- `progress` out 8: `mem_addr[ADDR_W-1 -: 8]`, or zero-extended `mem_addr` if ADDR_W<8.

## Operation
- States: IDLE, SETTLE, REQ, NEXT, DONE.
- IDLE/DONE, `start`=1 → SETTLE.
  - Load `mem_addr`=START_ADDR and settle counter=0.
  - Reseed the pattern.
  - Clear `done`; set `busy`.
- SETTLE: count to SETTLE_CYC-1, then → REQ. If SETTLE_CYC=0, go straight to REQ.
- REQ:
  - `mem_req`=1 unless `pause`.
  - A transfer occurs on any cycle with `mem_req`&`mem_ack`; then → NEXT.
  - `mem_ack` while `mem_req`=0 is ignored.
- NEXT:
  - `mem_req`=0.
  - If `mem_addr`==END_ADDR → DONE (`busy`=0, `done`=1).
  - Otherwise increment `mem_addr`, advance the pattern, and → REQ.
- Handshake rules:
  - Once `mem_req` is high, `mem_req`, `mem_addr` and `mem_din` stay stable until acknowledged.
  - `pause` rising while `mem_req`=1 does not drop the request. It only blocks re-assertion in later REQ cycles.
- Address arithmetic:
  - The end comparison happens before the increment, so `mem_addr` never wraps.
  - END_ADDR=2**ADDR_W-1 terminates without overflow.
- `start` during SETTLE/REQ/NEXT is ignored.
- `start` in DONE restarts the sweep.
- `RESET` mid-sweep: next cycle is IDLE. Any outstanding request is abandoned.
- Reset values: `mem_req`=0, `mem_addr`=START_ADDR, `mem_din`=0, `busy`=0, `done`=0, `progress` derived from `mem_addr`.

## Timing
- `start` is sampled at edge 0.
  - `busy`=1 from cycle 1.
  - `mem_req`=1 from cycle 1+SETTLE_CYC, with `pause`=0.
- With `mem_ack` tied high, one transfer every 2 cycles.
- Final handshake at cycle T: `mem_req`=0 at T+1; `done`=1 and `busy`=0 at T+2.
- All outputs are registered; there is no combinational path from `mem_ack` or `pause` to any output.

## Configuration
- `RAM_CLEAR_PATTERN_EN` defined:
  - `mem_din` is a 16-bit Fibonacci LFSR, taps bits 0,2,3,5, shifting right with the feedback into bit 15.
  - Seeded to 16'hACE1 on `start`; advances once per transfer in NEXT.
  - Replicated to DATA_W bits.
- Not defined: `mem_din` is constant 0 and no LFSR logic is synthesised.

## Structure
- Package `ram_clear_pkg` holds:
  - the state enum `ram_clear_state_t`;
  - `LFSR_SEED` = 16'hACE1;
  - the LFSR tap mask.
- One sub-module, `ram_clear_lfsr`: enable, load and 16-bit state. It is instantiated only under `RAM_CLEAR_PATTERN_EN`.

## Test plan
- Basic sweep:
  - Setup: START_ADDR=0, END_ADDR=7, SETTLE_CYC=9, `mem_ack`=1, `start` at edge 0.
  - Expect: 8 transfers at addresses 0..7 on cycles 10,12,…,24.
  - Expect: `done`=1 and `busy`=0 at cycle 26; `done` still 1 at cycle 100.
- Ack stall:
  - Stimulus: hold `mem_ack`=0 for 5 cycles during the 3rd request.
  - Expect: `mem_req`, `mem_addr`=2 and `mem_din` stable across the stall.
  - Expect: exactly 8 transfers, with no duplicate or skipped address.
- Pause:
  - Stimulus: assert `pause` in NEXT after address 3, for 6 cycles.
  - Expect: `mem_req` stays 0 until `pause` falls; address 4 is written afterwards.
  - Stimulus: assert `pause` while `mem_req`=1.
  - Expect: the request is held until acked.
- Reset and restart:
  - Stimulus: `RESET` at address 5.
  - Expect: the next cycle has `mem_req`=0, `busy`=0, `done`=0, `mem_addr`=0.
  - Stimulus: a `start` pulse while `busy`.
  - Expect: ignored, no restart.
- Full range:
  - Setup: ADDR_W=4, END_ADDR=15.
  - Expect: 16 transfers at addresses 0..15, `done` set, no wrap to 0.
  - Expect: `progress` equals `mem_addr` zero-extended.
- Pattern, with `RAM_CLEAR_PATTERN_EN`:
  - Expect: first three `mem_din` words 16'hACE1, 16'h5670, 16'hAB38.
  - Expect: a restart reproduces the same sequence.
  - Without the macro: every word is 0.

Source files
------------

// File: rtl/ram_clear_pkg.sv
// Shared types and constants for the RAM clear sequencer.
//   ram_clear_state_t : sweep FSM states
//   LFSR_SEED         : pattern seed loaded on every start
//   LFSR_TAPS         : Fibonacci tap mask (bits 0,2,3,5)
//   lfsr_step()       : one right shift with feedback into bit 15
package ram_clear_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StReq,
        StNext,
        StDone
    } ram_clear_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/ram_clear_lfsr.sv
// 16-bit Fibonacci LFSR used as the optional memory-test fill pattern.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (state -> 0)
//   load_i  : load LFSR_SEED (priority over en_i)
//   en_i    : advance one step
//   state_o : current LFSR state
module ram_clear_lfsr
    import ram_clear_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = LFSR_SEED;
        end else if (en_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/ram_clear_seq.sv
// Bounded, restartable, pausable write sweep from START_ADDR to END_ADDR
// (inclusive), one single-word write per address over a req/ack handshake.
// Optional macro: RAM_CLEAR_PATTERN_EN selects an LFSR fill pattern instead of zero.
// Ports:
//   clk_sys  : clock
//   RESET    : synchronous active-high reset
//   start    : begin/restart a sweep (honoured only when idle or done)
//   pause    : block new request assertion
//   mem_req  : write request (held until mem_ack)
//   mem_ack  : controller accepted request
//   mem_addr : write address
//   mem_din  : write data
//   busy     : sweep in progress
//   done     : sweep complete, held until next start or RESET
//   progress : upper 8 address bits (zero-extended if ADDR_W < 8)
module ram_clear_seq
    import ram_clear_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 25,
    parameter int unsigned       DATA_W     = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = '1,
    parameter int unsigned       SETTLE_CYC = 9
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              start,
    input  logic              pause,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              busy,
    output logic              done,
    output logic [7:0]        progress
);

    localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SetW-1:0] SettleLast = SetW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    ram_clear_state_t  state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SetW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            addr_q  <= START_ADDR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) state_d = (SETTLE_CYC == 0) ? StReq : StSettle;
            end
            StSettle: if (cnt_q == SettleLast) state_d = StReq;
            StReq:    if (req_q && mem_ack) state_d = StNext;
            StNext:   state_d = (addr_q == END_ADDR) ? StDone : StReq;
            default:  state_d = StIdle;
        endcase
    end

    // Request is computed a cycle ahead so every output stays registered;
    // pause only gates a fresh assertion, never an outstanding request.
    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        busy_d = busy_q;
        done_d = done_q;
        cnt_d  = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    addr_d = START_ADDR;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    req_d  = (SETTLE_CYC == 0) ? ~pause : 1'b0;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SettleLast) req_d = ~pause;
            end
            StReq: begin
                if (req_q) begin
                    if (mem_ack) req_d = 1'b0;
                end else begin
                    req_d = ~pause;
                end
            end
            StNext: begin
                // End test precedes increment, so the address never wraps.
                if (addr_q == END_ADDR) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                    req_d  = ~pause;
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

    if (ADDR_W >= 8) begin : g_prog_hi
        assign progress = addr_q[ADDR_W-1 -: 8];
    end else begin : g_prog_ext
        assign progress = {{(8 - ADDR_W){1'b0}}, addr_q};
    end

`ifdef RAM_CLEAR_PATTERN_EN
    logic        lfsr_load;
    logic        lfsr_en;
    logic [15:0] lfsr_state;

    assign lfsr_load = ((state_q == StIdle) || (state_q == StDone)) && start;
    assign lfsr_en   = (state_q == StNext) && (addr_q != END_ADDR);

    ram_clear_lfsr u_lfsr (
        .clk_i   (clk_sys),
        .rst_i   (RESET),
        .load_i  (lfsr_load),
        .en_i    (lfsr_en),
        .state_o (lfsr_state)
    );

    always_comb begin
        for (int i = 0; i < int'(DATA_W); i++) begin
            mem_din[i] = lfsr_state[i % 16];
        end
    end
`else
    assign mem_din = '0;
`endif

endmodule

// File: tb/tb_ram_clear_seq.sv
module tb_ram_clear_seq;

`ifdef RAM_CLEAR_PATTERN_EN
    localparam bit PatEn = 1'b1;
`else
    localparam bit PatEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_pause, a_ack, a_req, a_busy, a_done;
    logic [24:0] a_addr;
    logic [31:0] a_din;
    logic [7:0]  a_prog;
    logic        b_start, b_pause, b_ack, b_req, b_busy, b_done;
    logic [3:0]  b_addr;
    logic [15:0] b_din;
    logic [7:0]  b_prog;

    ram_clear_seq #(
        .ADDR_W     (25),
        .DATA_W     (32),
        .START_ADDR (25'd0),
        .END_ADDR   (25'd7),
        .SETTLE_CYC (9)
    ) u_dut_a (
        .clk_sys  (clk),
        .RESET    (rst),
        .start    (a_start),
        .pause    (a_pause),
        .mem_req  (a_req),
        .mem_ack  (a_ack),
        .mem_addr (a_addr),
        .mem_din  (a_din),
        .busy     (a_busy),
        .done     (a_done),
        .progress (a_prog)
    );

    ram_clear_seq #(
        .ADDR_W     (4),
        .DATA_W     (16),
        .SETTLE_CYC (0)
    ) u_dut_b (
        .clk_sys  (clk),
        .RESET    (rst),
        .start    (b_start),
        .pause    (b_pause),
        .mem_req  (b_req),
        .mem_ack  (b_ack),
        .mem_addr (b_addr),
        .mem_din  (b_din),
        .busy     (b_busy),
        .done     (b_done),
        .progress (b_prog)
    );

    int checks = 0;
    int errors = 0;
    int cur_cyc = 0;
    logic [63:0] x_addr[$];
    logic [63:0] x_din[$];
    int          x_cyc[$];
    int          exp_cyc[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cur_cyc, obs, exp);
        end
    endtask

    // Expected fill word for the k-th transfer of a sweep.
    function automatic logic [15:0] exp_word(input int k);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return PatEn ? s : 16'h0000;
    endfunction

    task automatic note_xfer(input logic req, input logic ack, input logic [63:0] addr,
                             input logic [63:0] din);
        if (req && ack) begin
            x_addr.push_back(addr);
            x_din.push_back(din);
            x_cyc.push_back(cur_cyc);
        end
    endtask

    task automatic clear_log();
        x_addr.delete();
        x_din.delete();
        x_cyc.delete();
    endtask

    task automatic check_list(input string tag, input int n, input bit wide);
        logic [15:0] w;
        chk({tag, "_count"}, 64'(x_addr.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            if (k < x_addr.size()) begin
                w = exp_word(k);
                chk({tag, "_addr"}, x_addr[k], 64'(k));
                chk({tag, "_din"}, x_din[k], wide ? 64'({w, w}) : 64'(w));
                chk({tag, "_cyc"}, 64'(x_cyc[k]), 64'(exp_cyc[k]));
            end
        end
    endtask

    task automatic start_a();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_start = 0; a_pause = 0; a_ack = 0;
        b_start = 0; b_pause = 0; b_ack = 0;
        repeat (3) tick();

        // Reset values
        chk("rst_a_req", a_req, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_a_din", a_din, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_prog", a_prog, 0);
        chk("rst_b_addr", b_addr, 0);
        chk("rst_b_prog", b_prog, 0);
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_a_busy", a_busy, 0);
        chk("idle_a_req", a_req, 0);

        // Basic sweep, ack tied high
        clear_log();
        a_ack = 1'b1;
        start_a();
        for (int c = 1; c <= 30; c++) begin
            cur_cyc = c;
            chk("sweep_busy", a_busy, c <= 25);
            chk("sweep_done", a_done, c >= 26);
            chk("sweep_req", a_req, (c >= 10) && (c <= 24) && (c % 2 == 0));
            chk("sweep_prog", a_prog, 0);
            note_xfer(a_req, a_ack, a_addr, a_din);
            tick();
        end
        for (int k = 0; k < 16; k++) exp_cyc[k] = 10 + 2 * k;
        check_list("sweep", 8, 1'b1);
`ifdef RAM_CLEAR_PATTERN_EN
        if (x_din.size() >= 3) begin
            chk("pat_w0", x_din[0][15:0], 16'hACE1);
            chk("pat_w1", x_din[1][15:0], 16'h5670);
            chk("pat_w2", x_din[2][15:0], 16'hAB38);
        end
`endif
        repeat (69) tick();
        cur_cyc = 100;
        chk("hold_done", a_done, 1);
        chk("hold_busy", a_busy, 0);
        chk("hold_addr", a_addr, 7);
        chk("hold_req", a_req, 0);

        // Ack stall on the third request; restart from DONE
        clear_log();
        start_a();
        cur_cyc = 1;
        chk("restart_done_clr", a_done, 0);
        chk("restart_busy", a_busy, 1);
        chk("restart_addr", a_addr, 0);
        for (int c = 1; c <= 35; c++) begin
            cur_cyc = c;
            a_ack = !((c >= 14) && (c <= 18));
            if ((c >= 14) && (c <= 18)) begin
                chk("stall_req", a_req, 1);
                chk("stall_addr", a_addr, 2);
                chk("stall_din", a_din, {exp_word(2), exp_word(2)});
            end
            note_xfer(a_req, a_ack, a_addr, a_din);
            tick();
        end
        for (int k = 0; k < 16; k++) exp_cyc[k] = (k < 2) ? 10 + 2 * k : (k == 2) ? 19 : 21 + 2 * (k - 3);
        check_list("stall", 8, 1'b1);
        chk("stall_done", a_done, 1);

        // Pause in NEXT after address 3, then pause while a request is up
        clear_log();
        start_a();
        for (int c = 1; c <= 40; c++) begin
            cur_cyc = c;
            a_pause = ((c >= 17) && (c <= 22)) || ((c >= 26) && (c <= 30));
            a_ack = !((c >= 26) && (c <= 28));
            if ((c >= 18) && (c <= 23)) chk("pause_blk_req", a_req, 0);
            if ((c >= 26) && (c <= 29)) begin
                chk("pause_hold_req", a_req, 1);
                chk("pause_hold_addr", a_addr, 5);
            end
            note_xfer(a_req, a_ack, a_addr, a_din);
            tick();
        end
        a_pause = 1'b0;
        a_ack = 1'b1;
        exp_cyc[0] = 10; exp_cyc[1] = 12; exp_cyc[2] = 14; exp_cyc[3] = 16;
        exp_cyc[4] = 24; exp_cyc[5] = 29; exp_cyc[6] = 32; exp_cyc[7] = 34;
        check_list("pause", 8, 1'b1);
        chk("pause_done", a_done, 1);

        // Start pulses while busy are ignored; RESET at address 5
        clear_log();
        start_a();
        for (int c = 1; c <= 20; c++) begin
            cur_cyc = c;
            a_start = (c == 5) || (c == 10) || (c == 11);
            rst = (c == 20);
            if (c == 20) chk("pre_rst_addr", a_addr, 5);
            if (c < 20) note_xfer(a_req, a_ack, a_addr, a_din);
            tick();
        end
        a_start = 1'b0;
        cur_cyc = 21;
        chk("mid_rst_req", a_req, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_done", a_done, 0);
        chk("mid_rst_addr", a_addr, 0);
        chk("mid_rst_din", a_din, 0);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) exp_cyc[k] = 10 + 2 * k;
        check_list("ignore_start", 5, 1'b1);
        repeat (5) tick();
        chk("post_rst_idle", a_busy, 0);

        // Full 4-bit range with zero settle cycles
        clear_log();
        b_ack = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            cur_cyc = c;
            chk("full_prog", b_prog, {4'h0, b_addr});
            chk("full_req", b_req, (c <= 31) && (c % 2 == 1));
            chk("full_busy", b_busy, c <= 32);
            chk("full_done", b_done, c >= 33);
            note_xfer(b_req, b_ack, b_addr, b_din);
            tick();
        end
        for (int k = 0; k < 16; k++) exp_cyc[k] = 1 + 2 * k;
        check_list("full", 16, 1'b0);
        chk("full_nowrap", b_addr, 15);
        chk("full_prog_end", b_prog, 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
